// File: rtl/datapath_muldiv.sv
// Register-file datapath with a single-cycle ALU and a multicycle shift-add multiply / restoring divide unit.
// Define DATAPATH_MULDIV_DIV_EN to enable the divide/remainder ops (13-15); multiply is always present.
module datapath_muldiv #(
    parameter int NBITS      = 32,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] RS1,
    input  logic [$clog2(NREGS)-1:0] RS2,
    input  logic [$clog2(NREGS)-1:0] RD,
    input  logic [NBITS-1:0]         IMM,
    input  logic [WIDTH_ALUF-1:0]    ALUControl,
    input  logic                     ALUSrc,
    input  logic                     MemtoReg,
    input  logic                     RegWrite,
    input  logic                     link,
    input  logic [NBITS-1:0]         pclink,
    input  logic                     Start,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Zero,
    output logic                     Neg,
    output logic                     Carry,
    output logic [NBITS-1:0]         PCReg,
    output logic [NBITS-3:0]         Address,
    output logic [NBITS-1:0]         WriteData,
    input  logic [NBITS-1:0]         ReadData
);
    localparam int RW = $clog2(NREGS);
    localparam int SW = $clog2(NBITS);
    localparam logic [WIDTH_ALUF-1:0] OP_ADD   = WIDTH_ALUF'(4'd0);
    localparam logic [WIDTH_ALUF-1:0] OP_SUB   = WIDTH_ALUF'(4'd1);
    localparam logic [WIDTH_ALUF-1:0] OP_AND   = WIDTH_ALUF'(4'd2);
    localparam logic [WIDTH_ALUF-1:0] OP_OR    = WIDTH_ALUF'(4'd3);
    localparam logic [WIDTH_ALUF-1:0] OP_XOR   = WIDTH_ALUF'(4'd4);
    localparam logic [WIDTH_ALUF-1:0] OP_SLL   = WIDTH_ALUF'(4'd5);
    localparam logic [WIDTH_ALUF-1:0] OP_SRL   = WIDTH_ALUF'(4'd6);
    localparam logic [WIDTH_ALUF-1:0] OP_SRA   = WIDTH_ALUF'(4'd7);
    localparam logic [WIDTH_ALUF-1:0] OP_SLT   = WIDTH_ALUF'(4'd8);
    localparam logic [WIDTH_ALUF-1:0] OP_SLTU  = WIDTH_ALUF'(4'd9);
    localparam logic [WIDTH_ALUF-1:0] OP_MUL   = WIDTH_ALUF'(4'd10);
    localparam logic [WIDTH_ALUF-1:0] OP_MULH  = WIDTH_ALUF'(4'd11);
    localparam logic [WIDTH_ALUF-1:0] OP_MULHU = WIDTH_ALUF'(4'd12);
    localparam logic [WIDTH_ALUF-1:0] OP_DIV   = WIDTH_ALUF'(4'd13);
    localparam logic [WIDTH_ALUF-1:0] OP_DIVU  = WIDTH_ALUF'(4'd14);
    localparam logic [WIDTH_ALUF-1:0] OP_REM   = WIDTH_ALUF'(4'd15);
`ifdef DATAPATH_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    logic [NBITS-1:0]      rf_q [NREGS];
    state_t                state_q, state_d;
    logic [WIDTH_ALUF-1:0] op_q, op_d;
    logic [RW-1:0]         rd_q, rd_d;
    logic [SW-1:0]         cnt_q, cnt_d;
    logic [NBITS-1:0]      hi_q, hi_d, lo_q, lo_d, bmag_q, bmag_d;
    logic                  a_neg_q, a_neg_d, b_neg_q, b_neg_d, b_zero_q, b_zero_d;

    logic [NBITS-1:0]   src_a_s, src_b_s, rs2_val_s, diff_s, alu_res_s, result_s, multi_res_s;
    logic [SW-1:0]      shamt_s;
    logic               is_multi_s, launch_s, l_signed_s, sc_wr_s, done_wr_s;
    logic [NBITS:0]     sum_s, r_sh_s, trial_s;
    logic [2*NBITS-1:0] prod_s, prod_neg_s;

    assign src_a_s   = (RS1 == {RW{1'b0}}) ? {NBITS{1'b0}} : rf_q[RS1];
    assign rs2_val_s = (RS2 == {RW{1'b0}}) ? {NBITS{1'b0}} : rf_q[RS2];
    assign src_b_s   = ALUSrc ? IMM : rs2_val_s;
    assign shamt_s   = src_b_s[SW-1:0];
    assign {Carry, diff_s} = {1'b0, src_a_s} + {1'b0, ~src_b_s} + {{NBITS{1'b0}}, 1'b1};
    assign Zero      = (diff_s == {NBITS{1'b0}});
    assign Neg       = ($signed(src_a_s) < $signed(src_b_s));
    assign PCReg     = src_a_s;
    assign WriteData = rs2_val_s;
    assign Address   = alu_res_s[NBITS-1:2];
    assign Busy      = (state_q != ST_IDLE);
    assign Done      = (state_q == ST_DONE);

    // Single-cycle ALU decode; multicycle opcodes produce zero here.
    always_comb begin
        alu_res_s = {NBITS{1'b0}};
        case (ALUControl)
            OP_ADD:  alu_res_s = src_a_s + src_b_s;
            OP_SUB:  alu_res_s = diff_s;
            OP_AND:  alu_res_s = src_a_s & src_b_s;
            OP_OR:   alu_res_s = src_a_s | src_b_s;
            OP_XOR:  alu_res_s = src_a_s ^ src_b_s;
            OP_SLL:  alu_res_s = src_a_s << shamt_s;
            OP_SRL:  alu_res_s = src_a_s >> shamt_s;
            OP_SRA:  alu_res_s = $unsigned($signed(src_a_s) >>> shamt_s);
            OP_SLT:  alu_res_s = {{(NBITS-1){1'b0}}, Neg};
            OP_SLTU: alu_res_s = {{(NBITS-1){1'b0}}, ~Carry};
            default: alu_res_s = {NBITS{1'b0}};
        endcase
    end

    assign result_s   = link ? pclink : (MemtoReg ? ReadData : alu_res_s);
    assign is_multi_s = (ALUControl >= OP_MUL) && (DIV_EN || (ALUControl <= OP_MULHU));
    assign launch_s   = (state_q == ST_IDLE) && Start && is_multi_s;
    assign l_signed_s = (ALUControl == OP_MULH) || (ALUControl == OP_DIV) || (ALUControl == OP_REM);
    assign sc_wr_s    = RegWrite && (ALUControl < OP_MUL) && !Busy && (RD != {RW{1'b0}});
    assign done_wr_s  = (state_q == ST_DONE) && (rd_q != {RW{1'b0}});

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_s) state_d = ST_RUN;
                else          state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_q == SW'(NBITS-1)) state_d = ST_DONE;
                else                       state_d = ST_RUN;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch on launch, then one shift-add or restoring-subtract step per RUN cycle.
    // Both algorithms run on magnitudes; signs are reapplied when the result is written.
    always_comb begin
        op_d     = op_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        bmag_d   = bmag_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        sum_s    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bmag_q} : {(NBITS+1){1'b0}});
        r_sh_s   = {hi_q, lo_q[NBITS-1]};
        trial_s  = r_sh_s - {1'b0, bmag_q};
        if (launch_s) begin
            op_d     = ALUControl;
            rd_d     = RD;
            cnt_d    = {SW{1'b0}};
            a_neg_d  = l_signed_s && src_a_s[NBITS-1];
            b_neg_d  = l_signed_s && src_b_s[NBITS-1];
            b_zero_d = (src_b_s == {NBITS{1'b0}});
            hi_d     = {NBITS{1'b0}};
            lo_d     = a_neg_d ? (~src_a_s + {{(NBITS-1){1'b0}}, 1'b1}) : src_a_s;
            bmag_d   = b_neg_d ? (~src_b_s + {{(NBITS-1){1'b0}}, 1'b1}) : src_b_s;
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q + {{(SW-1){1'b0}}, 1'b1};
            if (op_q >= OP_DIV) begin
                if (!trial_s[NBITS]) begin
                    hi_d = trial_s[NBITS-1:0];
                    lo_d = {lo_q[NBITS-2:0], 1'b1};
                end else begin
                    hi_d = r_sh_s[NBITS-1:0];
                    lo_d = {lo_q[NBITS-2:0], 1'b0};
                end
            end else begin
                hi_d = sum_s[NBITS:1];
                lo_d = {sum_s[0], lo_q[NBITS-1:1]};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign prod_s     = {hi_q, lo_q};
    assign prod_neg_s = ~prod_s + {{(2*NBITS-1){1'b0}}, 1'b1};

    // Final result selection with sign fix-up and divide-by-zero quotient override.
    always_comb begin
        multi_res_s = {NBITS{1'b0}};
        case (op_q)
            OP_MUL:   multi_res_s = prod_s[NBITS-1:0];
            OP_MULH:  multi_res_s = (a_neg_q ^ b_neg_q) ? prod_neg_s[2*NBITS-1:NBITS] : prod_s[2*NBITS-1:NBITS];
            OP_MULHU: multi_res_s = prod_s[2*NBITS-1:NBITS];
            OP_DIV:   multi_res_s = b_zero_q ? {NBITS{1'b1}} :
                                    ((a_neg_q ^ b_neg_q) ? (~lo_q + {{(NBITS-1){1'b0}}, 1'b1}) : lo_q);
            OP_DIVU:  multi_res_s = b_zero_q ? {NBITS{1'b1}} : lo_q;
            OP_REM:   multi_res_s = a_neg_q ? (~hi_q + {{(NBITS-1){1'b0}}, 1'b1}) : hi_q;
            default:  multi_res_s = {NBITS{1'b0}};
        endcase
    end

    // State and multicycle operand registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= {WIDTH_ALUF{1'b0}};
            rd_q     <= {RW{1'b0}};
            cnt_q    <= {SW{1'b0}};
            hi_q     <= {NBITS{1'b0}};
            lo_q     <= {NBITS{1'b0}};
            bmag_q   <= {NBITS{1'b0}};
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            bmag_q   <= bmag_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
        end
    end

    // Register file writes: multicycle completion and single-cycle results are mutually exclusive via Busy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= {NBITS{1'b0}};
        end else if (done_wr_s) begin
            rf_q[rd_q] <= multi_res_s;
        end else if (sc_wr_s) begin
            rf_q[RD] <= result_s;
        end
    end
endmodule

// File: tb/tb_datapath_muldiv.sv
// Self-checking bench for datapath_muldiv: randomized ALU/multicycle ops against an arithmetic reference model.
module tb_datapath_muldiv;
    logic        clock = 1'b0;
    logic        reset, ALUSrc, MemtoReg, RegWrite, link, Start;
    logic        Busy, Done, Zero, Neg, Carry;
    logic [4:0]  RS1, RS2, RD;
    logic [3:0]  ALUControl;
    logic [31:0] IMM, pclink, ReadData, PCReg, WriteData;
    logic [29:0] Address;

    logic [31:0] mrf [32];
    int n_pass  = 0;
    int n_total = 0;

    datapath_muldiv dut (
        .clock(clock), .reset(reset), .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM),
        .ALUControl(ALUControl), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .link(link), .pclink(pclink), .Start(Start), .Busy(Busy), .Done(Done),
        .Zero(Zero), .Neg(Neg), .Carry(Carry), .PCReg(PCReg), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        Start = 1'b0; RegWrite = 1'b0; link = 1'b0; MemtoReg = 1'b0; ALUSrc = 1'b0;
    endtask

    task automatic wr_reg(input logic [4:0] r, input logic [31:0] v);
        idle();
        RS1 = 5'd0; ALUSrc = 1'b1; IMM = v; ALUControl = 4'd0; RD = r; RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
        if (r != 5'd0) mrf[r] = v;
    endtask

    task automatic rd_chk(input logic [4:0] r, input string tag);
        RS1 = r;
        #1;
        chk(tag, PCReg, mrf[r]);
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = b[4:0];
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return $signed(a) >>> sh;
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_multi(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0] pu;
        ps = 64'($signed(a)) * 64'($signed(b));
        pu = {32'd0, a} * {32'd0, b};
        case (op)
            4'd10: return pu[31:0];
            4'd11: return ps[63:32];
            4'd12: return pu[63:32];
            4'd13: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            4'd14: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd15: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_multi(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input string tag);
        logic [31:0] exp;
        logic [4:0]  scr;
        int busy_n, done_at;
        exp = ref_multi(op, mrf[rs1], mrf[rs2]);
        scr = (rd == 5'd30) ? 5'd29 : 5'd30;
        idle();
        RS1 = rs1; RS2 = rs2; RD = rd; ALUControl = op; Start = 1'b1;
        tick();
        // Disturb every input while the op runs; single-cycle writes must be suppressed.
        Start = 1'b0; RS1 = 5'($urandom); RS2 = 5'($urandom); ALUControl = 4'd0;
        ALUSrc = 1'b1; IMM = $urandom; RD = scr; RegWrite = 1'b1;
        busy_n = 0; done_at = 0;
        for (int c = 1; c <= 60 && done_at == 0; c++) begin
            if (Busy) busy_n++;
            if (Done) done_at = c;
            else tick();
        end
        RegWrite = 1'b0; Start = 1'b1; ALUControl = 4'd10;
        tick();
        Start = 1'b0; ALUControl = 4'd0;
        chk({tag, "_done_cycle"}, 64'(done_at), 64'd33);
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
        chk({tag, "_idle_after"}, {63'd0, Busy}, 64'd0);
        if (rd != 5'd0) mrf[rd] = exp;
        rd_chk(rd, {tag, "_result"});
        rd_chk(scr, {tag, "_no_sc_write"});
    endtask

    initial begin
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] a, b, res;
        int sel, done_seen;

        idle();
        reset = 1'b0; RS1 = 5'd0; RS2 = 5'd0; RD = 5'd0; IMM = 32'd0; ALUControl = 4'd0;
        pclink = 32'd0; ReadData = 32'd0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        tick();
        reset = 1'b1;
        chk("reset_busy", {63'd0, Busy}, 64'd0);
        chk("reset_done", {63'd0, Done}, 64'd0);
        for (int i = 0; i < 32; i++) rd_chk(5'(i), "reset_reg");

        // ADDI to r3, then to r0 which must stay zero
        wr_reg(5'd3, 32'd5);
        rd_chk(5'd3, "addi_r3");
        wr_reg(5'd0, 32'd5);
        rd_chk(5'd0, "addi_r0");

        // Flags
        wr_reg(5'd1, 32'd3); wr_reg(5'd2, 32'd5); wr_reg(5'd6, 32'd9);
        RS1 = 5'd1; RS2 = 5'd2; ALUSrc = 1'b0; #1;
        chk("flag_zero_35", {63'd0, Zero}, 64'd0);
        chk("flag_neg_35", {63'd0, Neg}, 64'd1);
        chk("flag_carry_35", {63'd0, Carry}, 64'd0);
        chk("writedata_r2", {32'd0, WriteData}, 64'd5);
        RS1 = 5'd6; ALUSrc = 1'b1; IMM = 32'd9; #1;
        chk("flag_zero_99", {63'd0, Zero}, 64'd1);
        chk("flag_carry_99", {63'd0, Carry}, 64'd1);

        // Start with a single-cycle op is ignored
        idle(); ALUControl = 4'd0; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("start_sc_ignored", {63'd0, Busy}, 64'd0);

        for (int r = 1; r < 32; r++) wr_reg(5'(r), $urandom);

        // Randomized single-cycle ops against the model
        for (int k = 0; k < 40; k++) begin
            idle();
            op = 4'($urandom_range(0, 9));
            rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
            ALUSrc = 1'($urandom); IMM = $urandom;
            if (k % 4 == 0) IMM = IMM & 32'h0000_003F;
            ALUControl = op; RS1 = rs1; RS2 = rs2; RD = rd;
            pclink = $urandom; ReadData = $urandom;
            sel = $urandom_range(0, 3);
            link = (sel == 0); MemtoReg = (sel == 1);
            #1;
            a = mrf[rs1];
            b = ALUSrc ? IMM : mrf[rs2];
            res = ref_alu(op, a, b);
            chk("alu_address", {34'd0, Address}, {34'd0, res[31:2]});
            chk("flag_zero", {63'd0, Zero}, {63'd0, (a == b)});
            chk("flag_neg", {63'd0, Neg}, {63'd0, ($signed(a) < $signed(b))});
            chk("flag_carry", {63'd0, Carry}, {63'd0, (a >= b)});
            RegWrite = 1'b1;
            tick();
            if (rd != 5'd0) mrf[rd] = (sel == 0) ? pclink : ((sel == 1) ? ReadData : res);
            idle();
            rd_chk(rd, "sc_write");
        end

        // MULH of -1 by 2
        wr_reg(5'd1, 32'hFFFF_FFFF); wr_reg(5'd2, 32'd2);
        run_multi(4'd11, 5'd1, 5'd2, 5'd4, "mulh_dir");

        for (int k = 0; k < 6; k++) begin
            rs1 = 5'($urandom_range(1, 15)); rs2 = 5'($urandom_range(16, 28));
            wr_reg(rs1, $urandom); wr_reg(rs2, $urandom);
            run_multi(4'($urandom_range(10, 12)), rs1, rs2, 5'($urandom_range(1, 28)), "mul_rand");
        end

`ifdef DATAPATH_MULDIV_DIV_EN
        wr_reg(5'd1, 32'd7); wr_reg(5'd2, 32'd0);
        run_multi(4'd13, 5'd1, 5'd2, 5'd6, "div_by0");
        run_multi(4'd15, 5'd1, 5'd2, 5'd7, "rem_by0");
        wr_reg(5'd1, 32'h8000_0000); wr_reg(5'd2, 32'hFFFF_FFFF);
        run_multi(4'd13, 5'd1, 5'd2, 5'd8, "div_ovf");
        for (int k = 0; k < 6; k++) begin
            rs1 = 5'($urandom_range(1, 15)); rs2 = 5'($urandom_range(16, 28));
            wr_reg(rs1, $urandom); wr_reg(rs2, $urandom >> $urandom_range(0, 30));
            run_multi(4'($urandom_range(13, 15)), rs1, rs2, 5'($urandom_range(1, 28)), "div_rand");
        end
`else
        wr_reg(5'd1, 32'd7); wr_reg(5'd2, 32'd3);
        idle(); RS1 = 5'd1; RS2 = 5'd2; ALUControl = 4'd13; Start = 1'b1; #1;
        chk("div_dis_alures", {34'd0, Address}, 64'd0);
        tick();
        Start = 1'b0;
        chk("div_dis_nobusy", {63'd0, Busy}, 64'd0);
`endif

        // Reset during RUN aborts the op without a write
        wr_reg(5'd5, 32'h0000_1234);
        idle(); RS1 = 5'd1; RS2 = 5'd2; RD = 5'd5; ALUControl = 4'd10; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        chk("mid_run_busy", {63'd0, Busy}, 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        chk("abort_busy", {63'd0, Busy}, 64'd0);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (Done) done_seen++;
            tick();
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        rd_chk(5'd5, "abort_r5");
        rd_chk(5'd1, "abort_r1");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/datapath_muldiv.md
DATAPATH_MULDIV -- requirements
Module: datapath_muldiv

Interface
REQ-001 SHALL have parameter NBITS, default 32, datapath and register width (8..64, even).
REQ-002 SHALL have parameter NREGS, default 32, register file depth (power of two, >= 2).
REQ-003 SHALL have parameter WIDTH_ALUF, default 4, ALUControl width.
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset; reset==0 at a rising edge of clock resets the block.
REQ-006 SHALL have ports RS1, RS2, RD  in  $clog2(NREGS) each  register selects.
REQ-007 SHALL have port IMM  in  NBITS  signed immediate.
REQ-008 SHALL have port ALUControl  in  WIDTH_ALUF  operation select.
REQ-009 SHALL have ports ALUSrc, MemtoReg, RegWrite, link  in  1 each  SrcB=IMM, Result=ReadData, write enable, Result=pclink.
REQ-010 SHALL have port pclink  in  NBITS  PC value for link writes.
REQ-011 SHALL have port Start  in  1  launch of a multicycle op.
REQ-012 SHALL have ports Busy, Done  out  1 each  multicycle unit active, one-cycle completion pulse.
REQ-013 SHALL have ports Zero, Neg, Carry  out  1 each  compare flags from SrcA-SrcB.
REQ-014 SHALL have port PCReg  out  NBITS  equal to SrcA.
REQ-015 SHALL have ports Address  out  NBITS-2 (ALUResult[NBITS-1:2]), WriteData  out  NBITS (reg[RS2]), ReadData  in  NBITS.

Function
REQ-016 SHALL read SrcA=reg[RS1], SrcB=ALUSrc?IMM:reg[RS2] combinationally; reg[0] SHALL always read 0.
REQ-017 SHALL decode ALUControl: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU (single-cycle); 10 MUL,11 MULH,12 MULHU,13 DIV,14 DIVU,15 REM (multicycle); shifts use SrcB[$clog2(NBITS)-1:0].
REQ-018 SHALL compute {Carry,diff}=SrcA+~SrcB+1 over NBITS+1 bits; Zero=(diff==0); Neg=signed SrcA<SrcB.
REQ-019 SHALL write Result (link?pclink : MemtoReg?ReadData : ALUResult) to reg[RD] at the clock edge when RegWrite=1, ALUControl<10, Busy=0, RD!=0.
REQ-020 SHALL implement FSM IDLE->RUN->DONE->IDLE; IDLE->RUN when Start=1 and ALUControl>=10 and reset=1; Start with ALUControl<10 SHALL be ignored.
REQ-021 On IDLE->RUN SHALL latch SrcA, SrcB, op and RD; later input changes SHALL not affect the op.
REQ-022 RUN SHALL last exactly NBITS cycles (one shift-add or restoring-subtract step per cycle); Busy=1 in RUN and DONE.
REQ-023 In DONE (one cycle) SHALL assert Done=1, write result to latched RD if RD!=0, then return to IDLE; Start in DONE SHALL be ignored.
REQ-024 MUL SHALL give low NBITS of product; MULH high NBITS signed x signed; MULHU high NBITS unsigned.
REQ-025 Divide by zero SHALL give quotient all-ones, remainder = dividend; signed overflow (min/-1) SHALL give quotient = min, remainder 0; REM sign follows dividend.
REQ-026 Single-cycle register writes SHALL be suppressed while Busy=1; reads and flags SHALL stay live.

Reset
REQ-027 When reset=0 at a clock edge, all registers SHALL become 0, FSM IDLE, Busy=0, Done=0, latched operands 0.
REQ-028 Reset in RUN or DONE SHALL abort the op with no register write.

Configuration
REQ-029 With macro DATAPATH_MULDIV_DIV_EN defined, ops 13-15 SHALL run per REQ-022..025.
REQ-030 Without DATAPATH_MULDIV_DIV_EN, ops 13-15 SHALL be ignored like ALUControl<10 under Start (no Busy), and ALUResult SHALL be 0 for them; multiply SHALL remain.

Verification
REQ-031 Reset: reset=0 one edge -> all reg reads 0, Busy=0, Done=0.
REQ-032 ADDI: RS1=0, IMM=5, ALUSrc=1, RD=3, RegWrite=1 -> reg[3]=5 next cycle; RD=0 -> reg[0] stays 0.
REQ-033 MULH: reg1=0xFFFFFFFF, reg2=2, Start, op 11, RD=4 -> Busy for 33 cycles, Done on cycle 33 after Start, reg[4]=0xFFFFFFFF.
REQ-034 DIV by zero: reg1=7, reg2=0, op 13 -> quotient 0xFFFFFFFF; op 15 -> 7; DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000.
REQ-035 Reset mid-RUN: Start MUL RD=5, reset=0 at cycle 10 -> reg[5]=0, no Done pulse.
REQ-036 Flags: SrcA=3, SrcB=5 -> Zero=0, Neg=1, Carry=0; SrcA=SrcB=9 -> Zero=1, Carry=1.
